// File: rtl/binary_to_bcd.sv
// Sequential 8-bit binary to 3-digit BCD converter (double dabble, one bit per clock).
// Start/busy/done handshake; result registers hold the last completed conversion.
module binary_to_bcd (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] Value,
    output logic       busy,
    output logic       done,
    output logic [3:0] Units,
    output logic [3:0] Tens,
    output logic [1:0] Hundreds,
    output logic       Zero,
    output logic       state_dbg
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]  state;
    logic [2:0]  count;
    logic [19:0] scratch;
    logic [19:0] adjusted;
    logic [19:0] shifted;
    logic        zero_cap;

    // Handshake: start is taken only while idle (busy=0); busy stays high for the
    // eight shift cycles; done pulses for one cycle as the new digits appear.
    assign busy      = (state == SHIFT);
    assign state_dbg = state;

    // Scratch layout is {h, t, u, b}; each BCD nibble is corrected before the shift.
    always_comb begin
        adjusted = scratch;
        if (scratch[19:16] >= 4'd5) adjusted[19:16] = scratch[19:16] + 4'd3;
        if (scratch[15:12] >= 4'd5) adjusted[15:12] = scratch[15:12] + 4'd3;
        if (scratch[11:8]  >= 4'd5) adjusted[11:8]  = scratch[11:8]  + 4'd3;
        shifted = adjusted << 1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            count    <= 3'd0;
            scratch  <= 20'd0;
            zero_cap <= 1'b1;
            done     <= 1'b0;
            Units    <= 4'd0;
            Tens     <= 4'd0;
            Hundreds <= 2'd0;
            Zero     <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        scratch  <= {12'd0, Value};
                        count    <= 3'd0;
                        zero_cap <= (Value == 8'd0);
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch <= shifted;
                    count   <= count + 3'd1;
                    if (count == 3'd7) begin
                        // h never exceeds 2 for an 8-bit operand, so h[3:2] is always zero
                        Units    <= shifted[11:8];
                        Tens     <= shifted[15:12];
                        Hundreds <= shifted[17:16];
                        Zero     <= zero_cap;
                        done     <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/binary_to_bcd.md
# binary_to_bcd

Sequential binary-to-BCD converter for the calculator datapath. It takes the 8-bit unsigned ALU result and produces the Units/Tens/Hundreds digits and Zero flag consumed by the seven-segment display decoder. It sits between the ALU output register and the display decoder. Conversion uses iterative shift-and-add-3 (double dabble), one bit per clock, with a start/busy/done handshake.

## Interface
- No parameters; operand width is fixed at 8 bits and the digit widths are fixed.
- Clocking and reset: one clock; reset is asynchronous and active-high.
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; forces the reset state immediately.
- start  input  1  request a conversion of Value; sampled only in IDLE.
- Value  input  8  unsigned binary operand, 0..255; sampled on the accepting edge only.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when new digits are valid.
- Units  output  4  BCD units digit, 0..9.
- Tens  output  4  BCD tens digit, 0..9.
- Hundreds  output  2  hundreds digit, 0..2, in binary.
- Zero  output  1  high when the last converted Value was 0.

## Operation
- Internal 20-bit scratch is laid out as {h[3:0], t[3:0], u[3:0], b[7:0]}.
- A 3-bit iteration counter runs alongside the FSM.
- FSM states are IDLE and SHIFT.
- IDLE with start=1: load scratch = {12'b0, Value}, counter = 0, go to SHIFT, busy=1.
- IDLE with start=0: hold state; outputs hold.
- SHIFT, each cycle:
  - for each of h, t, u: if the nibble is ≥5, add 3 (4-bit add, no carry out of the nibble);
  - then shift the whole 20-bit scratch left by 1;
  - counter increments.
- Exit from SHIFT on the 8th iteration (counter == 7):
  - Units ← post-shift u;
  - Tens ← post-shift t;
  - Hundreds ← post-shift h[1:0];
  - Zero ← (Value captured at start == 0), tracked as a 1-bit register;
  - done=1, busy=0, go to IDLE.
- h never exceeds 2 for 8-bit input, so dropping h[3:2] is lossless.
- start while busy is ignored; there is no queueing and Value is not re-sampled.
- start asserted in the cycle where done=1 (FSM already in IDLE) is accepted normally, giving back-to-back conversions.
- Outputs Units, Tens, Hundreds and Zero hold the last completed result until the next completion. They never show intermediate values.

## Timing
- Reset values:
  - state = IDLE, counter = 0, scratch = 0;
  - busy = 0, done = 0;
  - Units = 0, Tens = 0, Hundreds = 0;
  - Zero = 1, so the display shows 000.
- Latency: if start is accepted at edge N, the result is registered and done=1 after edge N+8. busy is high from after edge N until edge N+8.
- Throughput: one conversion per 9 cycles when start is held high continuously.
- done is high for exactly one cycle per conversion; it is never asserted without a preceding accepted start.
- Reset asserted mid-conversion:
  - aborts immediately;
  - all outputs take their reset values;
  - no done pulse is generated;
  - after reset deasserts the block is in IDLE and the next start is accepted.
- reset has priority over start on the same edge.

## Test plan
- Reset then idle: after reset, Units=0, Tens=0, Hundreds=0, Zero=1, busy=0, done=0. Holding start=0 for 20 cycles leaves all outputs unchanged.
- Value=255, start for 1 cycle: done is seen exactly 8 cycles after the accepting edge with Hundreds=2, Tens=5, Units=5, Zero=0. busy is high for 8 cycles.
- Value=109 then Value=0 back-to-back, with start re-asserted on the done cycle:
  - first result is 1/0/9 with Zero=0;
  - second done comes 9 cycles after the first, with 0/0/0 and Zero=1.
- start and a new Value (e.g. 77) asserted while busy during a conversion of 42: the result is 0/4/2, only one done pulse occurs, and 77 is never converted.
- Reset asserted at the 4th SHIFT cycle of a conversion of 200:
  - outputs return to 0/0/0, Zero=1, busy=0 asynchronously;
  - no done pulse;
  - a following start with Value=200 yields 2/0/0.
- Exhaustive sweep of Value 0..255: every result satisfies Hundreds*100 + Tens*10 + Units == Value. Every digit is ≤9 and Hundreds is ≤2.
